// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the push-button front-end: per-channel FSM encoding
// and default board timing constants.
package button_conditioner_pkg;

   localparam logic [1:0] ST_IDLE   = 2'd0;
   localparam logic [1:0] ST_HELD   = 2'd1;
   localparam logic [1:0] ST_REPEAT = 2'd2;

   typedef enum logic [1:0] {
      IDLE   = ST_IDLE,
      HELD   = ST_HELD,
      REPEAT = ST_REPEAT
   } btn_state_e;

   localparam int N_BTN_DEF   = 8;
   localparam int DEB_CYC_DEF = 20;
   localparam int RPT_DLY_DEF = 500;
   localparam int RPT_PER_DEF = 100;
   localparam int CNT_W_DEF   = 10;

endpackage

// File: rtl/button_conditioner_if.sv
// Button bundle between the raw pins / edit logic and the conditioner.
interface button_conditioner_if #(
   parameter int N_BTN = 8
);
   logic [N_BTN-1:0] buttons_raw;
   logic [N_BTN-1:0] rpt_en;
   logic [N_BTN-1:0] buttons_level;
   logic [N_BTN-1:0] buttons_pulse;
   logic             any_press;

   modport master (
      output buttons_raw, rpt_en,
      input  buttons_level, buttons_pulse, any_press
   );

   modport slave (
      input  buttons_raw, rpt_en,
      output buttons_level, buttons_pulse, any_press
   );
endinterface

// File: rtl/button_channel.sv
// One button: 2-flop synchroniser, counter debounce and press/auto-repeat FSM.
module button_channel
   import button_conditioner_pkg::*;
#(
   parameter int DEB_CYC = DEB_CYC_DEF,
   parameter int RPT_DLY = RPT_DLY_DEF,
   parameter int RPT_PER = RPT_PER_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic clk,
   input  logic rst,
   input  logic i_raw,
   input  logic i_rpt_en,
   output logic o_level,
   output logic o_pulse,
   output logic o_pulse_nxt
);

   localparam logic [CNT_W-1:0] DEB_LIM = CNT_W'(DEB_CYC - 1);
   localparam logic [CNT_W-1:0] DLY_LIM = CNT_W'(RPT_DLY - 1);
   localparam logic [CNT_W-1:0] PER_LIM = CNT_W'(RPT_PER - 1);

   logic [1:0]       r_sync;
   logic             r_level;
   logic [CNT_W-1:0] r_deb_cnt;
   btn_state_e       r_state;
   logic [CNT_W-1:0] r_rep_cnt;
   logic             r_pulse;

   logic             w_differ;
   logic             w_deb_done;
   logic             w_level_nxt;
   logic             w_rise;
   logic [CNT_W-1:0] w_deb_nxt;
   btn_state_e       w_state_nxt;
   logic [CNT_W-1:0] w_rep_nxt;
   logic             w_pulse_nxt;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_sync <= '0;
      else      r_sync <= {r_sync[0], i_raw};
   end

   // The FSM acts on the next debounced level so the press pulse lands in the
   // same cycle buttons_level goes high.
   always_comb begin
      w_differ    = r_sync[1] ^ r_level;
      w_deb_done  = w_differ && (r_deb_cnt == DEB_LIM);
      w_level_nxt = r_level ^ w_deb_done;
      w_rise      = w_deb_done & ~r_level;
      w_deb_nxt   = '0;
      if (w_differ && !w_deb_done && (r_deb_cnt < DEB_LIM))
         w_deb_nxt = r_deb_cnt + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_level   <= 1'b0;
         r_deb_cnt <= '0;
      end else begin
         r_level   <= w_level_nxt;
         r_deb_cnt <= w_deb_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_rep_nxt   = r_rep_cnt;
      w_pulse_nxt = 1'b0;
      case (r_state)
         IDLE: begin
            w_rep_nxt = '0;
            if (w_rise) begin
               w_state_nxt = HELD;
               w_pulse_nxt = 1'b1;
            end
         end
         HELD: begin
            if (!w_level_nxt) begin
               w_state_nxt = IDLE;
               w_rep_nxt   = '0;
            end else if (!i_rpt_en) begin
               w_rep_nxt = '0;
            end else if (r_rep_cnt >= DLY_LIM) begin
               w_state_nxt = REPEAT;
               w_pulse_nxt = 1'b1;
               w_rep_nxt   = '0;
            end else begin
               w_rep_nxt = r_rep_cnt + CNT_W'(1);
            end
         end
         REPEAT: begin
            if (!w_level_nxt) begin
               w_state_nxt = IDLE;
               w_rep_nxt   = '0;
            end else if (!i_rpt_en) begin
               w_state_nxt = HELD;
               w_rep_nxt   = '0;
            end else if (r_rep_cnt >= PER_LIM) begin
               w_pulse_nxt = 1'b1;
               w_rep_nxt   = '0;
            end else begin
               w_rep_nxt = r_rep_cnt + CNT_W'(1);
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_rep_nxt   = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state   <= IDLE;
         r_rep_cnt <= '0;
         r_pulse   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_rep_cnt <= w_rep_nxt;
         r_pulse   <= w_pulse_nxt;
      end
   end

   assign o_level     = r_level;
   assign o_pulse     = r_pulse;
   assign o_pulse_nxt = w_pulse_nxt;

endmodule

// File: rtl/button_conditioner.sv
// Push-button front-end: N_BTN independent channels plus a registered any_press.
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter int N_BTN   = N_BTN_DEF,
   parameter int DEB_CYC = DEB_CYC_DEF,
   parameter int RPT_DLY = RPT_DLY_DEF,
   parameter int RPT_PER = RPT_PER_DEF,
   parameter int CNT_W   = CNT_W_DEF
) (
   input  logic                 clk,
   input  logic                 rst,
   button_conditioner_if.slave  bus
);

   logic [N_BTN-1:0] w_level;
   logic [N_BTN-1:0] w_pulse;
   logic [N_BTN-1:0] w_pulse_nxt;
   logic             r_any_press;

   for (genvar g = 0; g < N_BTN; g++) begin : g_ch
      button_channel #(
         .DEB_CYC (DEB_CYC),
         .RPT_DLY (RPT_DLY),
         .RPT_PER (RPT_PER),
         .CNT_W   (CNT_W)
      ) u_ch (
         .clk         (clk),
         .rst         (rst),
         .i_raw       (bus.buttons_raw[g]),
         .i_rpt_en    (bus.rpt_en[g]),
         .o_level     (w_level[g]),
         .o_pulse     (w_pulse[g]),
         .o_pulse_nxt (w_pulse_nxt[g])
      );
   end

   // Built from the channels' next-pulse terms so it rises with buttons_pulse.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_any_press <= 1'b0;
      else      r_any_press <= |w_pulse_nxt;
   end

   assign bus.buttons_level = w_level;
   assign bus.buttons_pulse = w_pulse;
   assign bus.any_press     = r_any_press;

endmodule
